cic_comp_fir: RTL and testbench

- Compensation FIR directly downstream of the CIC decimator. Flattens the CIC sinc passband droop at the decimated rate.
- Consumes the CIC output data/strobe pair (i_data, i_ce) and produces one filtered sample per accepted input on o_data/o_ready.
- Output rate is low, so it uses a single time-shared multiplier-accumulator (serial MAC) instead of NTAPS parallel multipliers.

---
 rtl/cic_comp_fir_if.sv | 22 ++
 rtl/cic_comp_fir.sv | 126 ++++++++++++
 tb/tb_cic_comp_fir.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/cic_comp_fir_if.sv
// Sample/strobe bundle between the CIC decimator, the compensation FIR
// and whatever consumes the filtered stream.
interface cic_comp_fir_if #(
   parameter int IW = 10,
   parameter int OW = 12
);
   logic                 i_ce;
   logic signed [IW-1:0] i_data;
   logic signed [OW-1:0] o_data;
   logic                 o_ready;
   logic                 o_overrun;

   modport master (
      output i_ce, i_data,
      input  o_data, o_ready, o_overrun
   );

   modport slave (
      input  i_ce, i_data,
      output o_data, o_ready, o_overrun
   );
endinterface

// File: rtl/cic_comp_fir.sv
// CIC droop compensation FIR, one serial MAC per accepted sample.
// Define CIC_COMP_ROUND_EN for round-half-up instead of floor.
module cic_comp_fir #(
   parameter int                  IW    = 10,
   parameter int                  OW    = 12,
   parameter int                  NTAPS = 7,
   parameter int                  CW    = 8,
   parameter logic [NTAPS*CW-1:0] COEFS = 56'hFD_00_13_20_13_00_FD,
   parameter int                  SHIFT = 6
) (
   input logic           i_clk,
   input logic           i_reset,
   cic_comp_fir_if.slave bus
);
   localparam int AW   = IW + CW + $clog2(NTAPS);
   localparam int KW   = $clog2(NTAPS);
   localparam int RNDV = (1 << SHIFT) >> 1;

   localparam logic signed [AW-1:0] YMAX =
      AW'((1 << (OW - 1)) - 1);
   localparam logic signed [AW-1:0] YMIN = -YMAX - 1;

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;

   state_e               state_q, state_d;
   logic signed [IW-1:0] x_q [NTAPS];
   logic signed [AW-1:0] acc_q, acc_d;
   logic [KW-1:0]        tap_q, tap_d;
   logic signed [OW-1:0] data_q, data_d;
   logic                 ready_q, ready_d;
   logic                 ovr_q, ovr_d;
   logic                 shift_en;

   logic signed [IW-1:0] xs;
   logic signed [CW-1:0] cs;
   logic signed [AW-1:0] prod, sum, rnd, shf;
   logic signed [OW-1:0] sat;

   always_comb begin
      xs = '0;
      cs = '0;
      for (int k = 0; k < NTAPS; k++) begin
         if (tap_q == KW'(k)) begin
            xs = x_q[k];
            cs = COEFS[k*CW +: CW];
         end
      end
   end

   assign prod = AW'(xs) * AW'(cs);
   assign sum  = acc_q + prod;

`ifdef CIC_COMP_ROUND_EN
   assign rnd = sum + AW'(RNDV);
`else
   assign rnd = sum;
`endif

   assign shf = rnd >>> SHIFT;

   always_comb begin
      if (shf > YMAX)      sat = OW'(YMAX);
      else if (shf < YMIN) sat = OW'(YMIN);
      else                 sat = OW'(shf);
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      tap_d    = tap_q;
      data_d   = data_q;
      ready_d  = 1'b0;
      shift_en = 1'b0;
      ovr_d    = ovr_q;
      unique case (state_q)
         IDLE: begin
            if (bus.i_ce) begin
               shift_en = 1'b1;
               acc_d    = '0;
               tap_d    = '0;
               state_d  = MAC;
            end
         end
         MAC: begin
            acc_d = sum;
            tap_d = tap_q + KW'(1);
            // final tap: result lands on o_data for the OUT cycle
            if (tap_q == KW'(NTAPS - 1)) begin
               data_d  = sat;
               ready_d = 1'b1;
               state_d = OUT;
            end
         end
         OUT: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (bus.i_ce && state_q != IDLE) ovr_d = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         tap_q   <= '0;
         data_q  <= '0;
         ready_q <= 1'b0;
         ovr_q   <= 1'b0;
         for (int k = 0; k < NTAPS; k++) x_q[k] <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         tap_q   <= tap_d;
         data_q  <= data_d;
         ready_q <= ready_d;
         ovr_q   <= ovr_d;
         if (shift_en) begin
            x_q[0] <= bus.i_data;
            for (int k = 1; k < NTAPS; k++) x_q[k] <= x_q[k-1];
         end
      end
   end

   assign bus.o_data    = data_q;
   assign bus.o_ready   = ready_q;
   assign bus.o_overrun = ovr_q;
endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir: default instance plus an OW=10
// instance for clipping; honours CIC_COMP_ROUND_EN for expectations.
module tb_cic_comp_fir;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_run = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   cic_comp_fir_if #(.IW(10), .OW(12)) bus ();
   cic_comp_fir_if #(.IW(10), .OW(10)) sbus ();

   cic_comp_fir u_dut (
      .i_clk   (clk),
      .i_reset (rst_n),
      .bus     (bus)
   );

   cic_comp_fir #(.OW(10)) u_sat (
      .i_clk   (clk),
      .i_reset (rst_n),
      .bus     (sbus)
   );

`ifdef CIC_COMP_ROUND_EN
   int dc_exp [8] = '{-5, -5, 25, 75, 105, 105, 100, 100};
   int rnd_first  = 0;
   int rnd_centre = 1;
`else
   int dc_exp [8] = '{-5, -5, 25, 75, 104, 104, 100, 100};
   int rnd_first  = -1;
   int rnd_centre = 0;
`endif
   int imp_exp [7] = '{-3, 0, 19, 32, 19, 0, -3};
   int sat_pat [7] = '{-511, 0, 511, 511, 511, 0, -511};

   task automatic check(input string tag, input int got,
                        input int exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // strobe one sample, wait (bounded) for o_ready, return latency/data
   task automatic send(input bit s, input int v,
                       output int lat, output int y);
      @(posedge clk);
      #1;
      if (s) begin
         sbus.i_ce = 1'b1;
         sbus.i_data = 10'(v);
      end else begin
         bus.i_ce = 1'b1;
         bus.i_data = 10'(v);
      end
      @(posedge clk);
      #1;
      bus.i_ce = 1'b0;
      sbus.i_ce = 1'b0;
      lat = 1;
      while (lat < 20 && !(s ? sbus.o_ready : bus.o_ready)) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (s) y = int'(sbus.o_data);
      else   y = int'(bus.o_data);
      @(posedge clk);
   endtask

   initial begin
      int lat, y, pulses;
      bus.i_ce = 1'b0;
      bus.i_data = '0;
      sbus.i_ce = 1'b0;
      sbus.i_data = '0;
      #2;
      check("rst_data", int'(bus.o_data), 0);
      check("rst_ready", int'(bus.o_ready), 0);
      check("rst_ovr", int'(bus.o_overrun), 0);
      do_reset();

      send(0, 64, lat, y);
      check("pre_rst_y", y, -3);

      // reset three cycles into the MAC of a new sample
      @(posedge clk);
      #1 bus.i_ce = 1'b1;
      bus.i_data = 10'(100);
      @(posedge clk);
      #1 bus.i_ce = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_data", int'(bus.o_data), 0);
      check("mid_rst_ready", int'(bus.o_ready), 0);
      check("mid_rst_ovr", int'(bus.o_overrun), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      pulses = 0;
      repeat (15) begin
         @(posedge clk);
         #1;
         if (bus.o_ready) pulses++;
      end
      check("mid_rst_noready", pulses, 0);

      for (int i = 0; i < 7; i++) begin
         send(0, (i == 0) ? 64 : 0, lat, y);
         check($sformatf("imp_y%0d", i), y, imp_exp[i]);
         check($sformatf("imp_lat%0d", i), lat, 8);
      end

      do_reset();
      for (int i = 0; i < 8; i++) begin
         send(0, 100, lat, y);
         check($sformatf("dc_y%0d", i), y, dc_exp[i]);
      end

      do_reset();
      for (int i = 0; i < 7; i++) send(1, sat_pat[i], lat, y);
      check("sat_pos", y, 511);
      for (int i = 0; i < 7; i++) send(1, -sat_pat[i], lat, y);
      check("sat_neg", y, -512);

      // second strobe four cycles into the MAC must be dropped
      do_reset();
      @(posedge clk);
      #1 bus.i_ce = 1'b1;
      bus.i_data = 10'(64);
      @(posedge clk);
      #1 bus.i_ce = 1'b0;
      repeat (3) @(posedge clk);
      #1 bus.i_ce = 1'b1;
      bus.i_data = 10'(500);
      check("ovr_before", int'(bus.o_overrun), 0);
      @(posedge clk);
      #1 bus.i_ce = 1'b0;
      check("ovr_set", int'(bus.o_overrun), 1);
      lat = 5;
      while (lat < 20 && !bus.o_ready) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("ovr_lat", lat, 8);
      check("ovr_y", int'(bus.o_data), -3);
      @(posedge clk);
      send(0, 0, lat, y);
      check("ovr_next_y", y, 0);
      check("ovr_sticky", int'(bus.o_overrun), 1);
      do_reset();
      #1;
      check("ovr_clr", int'(bus.o_overrun), 0);

      send(0, 1, lat, y);
      check("rnd_first", y, rnd_first);
      for (int i = 0; i < 3; i++) send(0, 0, lat, y);
      check("rnd_centre", y, rnd_centre);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
